// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared encodings for the RV32I pipeline MEM stage
package rv_pipe_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    typedef enum logic {IDLE, WAIT} memState_t;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} accSize_t;

    // funct3[2] only selects zero-extension; 011/110/111 fall through to word
    function automatic accSize_t accessSize(input logic [2:0] funct3);
        if (funct3[1:0] == F3_LB[1:0])
            return SZ_BYTE;
        else if (funct3[1:0] == F3_LH[1:0])
            return SZ_HALF;
        else
            return SZ_WORD;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication/byte enables and load extraction
module lsu_align
    import rv_pipe_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLo,
    input  logic [31:0] storeData,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  byteEn,
    output logic [31:0] loadData
);

    accSize_t   size;
    logic       zeroExt;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    assign size     = accessSize(funct3);
    assign zeroExt  = funct3[2];
    assign loadByte = rdata[{addrLo, 3'b000} +: 8];
    assign loadHalf = rdata[{addrLo[1], 4'b0000} +: 16];

    always_comb begin
        wdata    = storeData;
        byteEn   = 4'b1111;
        loadData = rdata;
        case (size)
            SZ_BYTE: begin
                wdata    = {4{storeData[7:0]}};
                byteEn   = 4'b0001 << addrLo;
                loadData = {{24{~zeroExt & loadByte[7]}}, loadByte};
            end
            SZ_HALF: begin
                wdata    = {2{storeData[15:0]}};
                byteEn   = 4'b0011 << {addrLo[1], 1'b0};
                loadData = {{16{~zeroExt & loadHalf[15]}}, loadHalf};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory handshake, wait/timeout FSM, MEM/WB register
module mem_access_stage
    import rv_pipe_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] InstrM,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    output logic        StallM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUResultW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic        MisalignM,
    output logic        BusErrM
);

    localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);

    memState_t        state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [2:0]       funct3;
    logic             isLoad, memOp, misaligned, timeoutHit, bubble;
    logic [31:0]      loadData;
    logic [3:0]       storeBe;
    logic             unusedInstrBits;

    assign funct3          = InstrM[14:12];
    assign unusedInstrBits = ^{InstrM[31:15], InstrM[11:0]};
    assign isLoad          = (ResultSrcM == RES_LOAD);
    assign memOp           = MemWriteM | isLoad;

    lsu_align u_align (
        .funct3    (funct3),
        .addrLo    (ALUResultM[1:0]),
        .storeData (WriteDataM),
        .rdata     (dmem_rdata),
        .wdata     (dmem_wdata),
        .byteEn    (storeBe),
        .loadData  (loadData)
    );

    always_comb begin
        misaligned = 1'b0;
        case (accessSize(funct3))
            SZ_HALF: misaligned = memOp & ALUResultM[0];
            SZ_WORD: misaligned = memOp & (ALUResultM[1:0] != 2'b00);
            default: ;
        endcase
    end

    // rst gates the request so a reset during WAIT drops it without waiting for a clock
    assign timeoutHit = (state == WAIT) && (cnt == CNT_W'(BUS_TIMEOUT)) && !dmem_ready;
    assign dmem_req   = ~rst & memOp & ~misaligned & ~timeoutHit;
    assign dmem_we    = MemWriteM;
    assign dmem_addr  = {ALUResultM[31:2], 2'b00};
    assign dmem_be    = MemWriteM ? storeBe : 4'b1111;
    assign StallM     = dmem_req & ~dmem_ready;
    assign MisalignM  = misaligned;
    assign BusErrM    = timeoutHit;
    assign bubble     = StallM | misaligned | timeoutHit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = IDLE;
        cntNext   = '0;
        if (StallM) begin
            stateNext = WAIT;
            cntNext   = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ReadDataW  <= '0;
            ALUResultW <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
        end else if (bubble) begin
            ReadDataW  <= '0;
            ALUResultW <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
        end else begin
            ReadDataW  <= isLoad ? loadData : 32'h0;
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed and randomized checks of mem_access_stage against a transaction model
module tb_mem_access_stage;

    localparam int TO = 4;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
    } opT;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M, InstrM;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic        StallM, dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic        MisalignM, BusErrM;

    mem_access_stage #(.BUS_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .InstrM(InstrM),
        .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .ReadDataW(ReadDataW), .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W), .RdW(RdW),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .MisalignM(MisalignM), .BusErrM(BusErrM)
    );

    always #5 clk = ~clk;

    int   nChecks = 0;
    int   nFails  = 0;
    int   waited  = 0;
    int   stalls;
    logic lastStall = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // kind: 0 ALU, 1 load, 2 store, 3 jump (PC+4 writeback)
    function automatic opT mkOp(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] data, input logic [4:0] rd);
        opT o;
        o.alu   = addr;
        o.wd    = data;
        o.pc4   = 32'h0000_4000 + {25'h0, rd, 2'b00};
        o.instr = {17'h0, f3, 12'h0};
        o.instr[11:7] = rd;
        o.rd    = rd;
        o.rw    = (kind != 2);
        o.mw    = (kind == 2);
        o.rs    = (kind == 1) ? 2'b01 : (kind == 3) ? 2'b10 : 2'b00;
        return o;
    endfunction

    task automatic drive(input opT op);
        ALUResultM = op.alu;
        WriteDataM = op.wd;
        PCPlus4M   = op.pc4;
        InstrM     = op.instr;
        RdM        = op.rd;
        RegWriteM  = op.rw;
        MemWriteM  = op.mw;
        ResultSrcM = op.rs;
    endtask

    // One clock of the stage; waited = cycles this op has already been held without ready
    task automatic doCycle(input opT op, input logic rdy, input logic [31:0] rdat);
        logic [2:0]  f3;
        int          sz, off;
        logic        isLoad, memOp, mis, tOut, eReq, eStall, bubble;
        logic [31:0] v, eWdata;
        logic [3:0]  eBe;
        f3     = op.instr[14:12];
        isLoad = (op.rs == 2'b01);
        memOp  = op.mw || isLoad;
        sz     = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        off    = int'(op.alu % 4);
        mis    = memOp && (op.alu % sz != 0);
        tOut   = memOp && !mis && (waited == TO) && !rdy;
        eReq   = memOp && !mis && !tOut;
        eStall = eReq && !rdy;
        bubble = eStall || mis || tOut;
        v      = rdat >> (8 * off);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 128) v = v - 32'd256;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32768) v = v - 32'd65536;
        end else begin
            v = rdat;
        end
        eBe    = !op.mw ? 4'hF : (sz == 1) ? 4'(1 << off) : (sz == 2) ? 4'(3 << off) : 4'hF;
        eWdata = (sz == 1) ? (op.wd & 32'hFF) * 32'h0101_0101 :
                 (sz == 2) ? (op.wd & 32'hFFFF) * 32'h0001_0001 : op.wd;

        @(negedge clk);
        drive(op);
        dmem_ready = rdy;
        dmem_rdata = rdat;
        #1;
        check("dmem_req", dmem_req, eReq);
        check("StallM", StallM, eStall);
        check("MisalignM", MisalignM, mis);
        check("BusErrM", BusErrM, tOut);
        if (eReq) begin
            check("dmem_we", dmem_we, op.mw);
            check("dmem_addr", dmem_addr, op.alu & ~32'h3);
            check("dmem_be", dmem_be, eBe);
            if (op.mw) check("dmem_wdata", dmem_wdata, eWdata);
        end
        @(posedge clk);
        #1;
        check("ReadDataW", ReadDataW, (bubble || !isLoad) ? 32'h0 : v);
        check("ALUResultW", ALUResultW, bubble ? 32'h0 : op.alu);
        check("PCPlus4W", PCPlus4W, bubble ? 32'h0 : op.pc4);
        check("RdW", RdW, bubble ? 5'd0 : op.rd);
        check("RegWriteW", RegWriteW, bubble ? 1'b0 : op.rw);
        check("ResultSrcW", ResultSrcW, bubble ? 2'b00 : op.rs);
        waited    = eStall ? waited + 1 : 0;
        lastStall = eStall;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        opT   op;
        logic [2:0]  f3;
        logic [31:0] addr;
        int   kind, delay;

        rst = 1'b1;
        drive(mkOp(0, 3'd0, 32'h0, 32'h0, 5'd0));
        MemWriteM  = 1'b0;
        RegWriteM  = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_RegWriteW", RegWriteW, 1'b0);
        check("rst_RdW", RdW, 5'd0);
        check("rst_ALUResultW", ALUResultW, 32'h0);
        check("rst_ReadDataW", ReadDataW, 32'h0);
        check("rst_dmem_req", dmem_req, 1'b0);
        rst = 1'b0;

        // SW, zero-wait
        doCycle(mkOp(2, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0), 1'b1, 32'h0);
        check("sw_nostall", lastStall, 1'b0);

        // LB 0x103 with three wait cycles, then LBU
        stalls = 0;
        for (int c = 0; c < 4; c++) begin
            doCycle(mkOp(1, 3'b000, 32'h103, 32'h0, 5'd3), (c == 3), 32'h8012_3456);
            if (lastStall) stalls++;
        end
        check("lb_stalls", stalls, 3);
        check("lb_value", ReadDataW, 32'hFFFF_FF80);
        doCycle(mkOp(1, 3'b100, 32'h103, 32'h0, 5'd3), 1'b1, 32'h8012_3456);
        check("lbu_value", ReadDataW, 32'h0000_0080);

        // SH to upper half, then misaligned LW
        doCycle(mkOp(2, 3'b001, 32'h202, 32'h0000_ABCD, 5'd0), 1'b1, 32'h0);
        doCycle(mkOp(1, 3'b010, 32'h201, 32'h0, 5'd9), 1'b1, 32'h1234_5678);
        check("misalign_RegWriteW", RegWriteW, 1'b0);

        // LW that never completes: timeout
        stalls = 0;
        for (int c = 0; c < TO + 1; c++) begin
            doCycle(mkOp(1, 3'b010, 32'h300, 32'h0, 5'd4), 1'b0, 32'h0);
            if (lastStall) stalls++;
        end
        check("timeout_stalls", stalls, TO);
        doCycle(mkOp(0, 3'b000, 32'h55, 32'h0, 5'd2), 1'b0, 32'h0);

        // reset mid-WAIT
        doCycle(mkOp(1, 3'b010, 32'h400, 32'h0, 5'd8), 1'b0, 32'h0);
        doCycle(mkOp(1, 3'b010, 32'h400, 32'h0, 5'd8), 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstwait_req", dmem_req, 1'b0);
        check("rstwait_StallM", StallM, 1'b0);
        check("rstwait_RegWriteW", RegWriteW, 1'b0);
        check("rstwait_RdW", RdW, 5'd0);
        check("rstwait_ReadDataW", ReadDataW, 32'h0);
        op = mkOp(0, 3'b000, 32'h0, 32'h0, 5'd0);
        op.rw = 1'b0;
        drive(op);
        #2 rst = 1'b0;
        waited = 0;
        doCycle(mkOp(0, 3'b000, 32'h77, 32'h0, 5'd7), 1'b0, 32'h0);
        check("post_rst_add_rd", RdW, 5'd7);

        // back-to-back ADD x5, LW x6
        doCycle(mkOp(0, 3'b000, 32'h1234, 32'h0, 5'd5), 1'b0, 32'h0);
        check("b2b_rd5", RdW, 5'd5);
        check("b2b_src_alu", ResultSrcW, 2'b00);
        doCycle(mkOp(1, 3'b010, 32'h500, 32'h0, 5'd6), 1'b1, 32'hCAFE_F00D);
        check("b2b_rd6", RdW, 5'd6);
        check("b2b_src_load", ResultSrcW, 2'b01);
        check("b2b_lw_data", ReadDataW, 32'hCAFE_F00D);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 3));
            f3   = 3'($urandom_range(0, 7));
            if (kind == 2 && (f3 == 3'd4 || f3 == 3'd5)) f3 = 3'd2;
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            op    = mkOp(kind, f3, addr, $urandom, 5'($urandom_range(0, 31)));
            delay = int'($urandom_range(0, 6));
            for (int c = 0; c < 10; c++) begin
                doCycle(op, (waited == delay), $urandom);
                if (!lastStall) break;
            end
            check("rand_bounded", lastStall, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
